fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the 8-bit memory/register file.
- Holds the program counter (PC) and drives the memory read address; the memory returns read data combinationally in the same cycle.
- Assembles 1- or 2-byte instructions and presents them to the decode stage over a valid/ready handshake.
- Accepts a branch redirect from execute.

Parameters:
- ADDR_W, 8, PC and memory address width.
- DATA_W, 8, memory byte and opcode/immediate width.
- RESET_PC, 8'h00, PC value loaded on reset.
- LONG_BIT, 7, opcode bit that marks a 2-byte instruction (1 = opcode + immediate byte follows).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- fetch_en  in  1  1 = allow new opcode fetches; 0 = park in FETCH_OP.
- mem_addr  out  ADDR_W  memory read address.
- mem_rd  out  1  memory read strobe.
- mem_rdata  in  DATA_W  memory read data, valid in the same cycle as mem_addr.
- redirect  in  1  branch taken; load PC from redirect_pc.
- redirect_pc  in  ADDR_W  branch target.
- instr_valid  out  1  instruction held for decode.
- instr_ready  in  1  decode accepts the instruction.
- instr_opcode  out  DATA_W  opcode byte.
- instr_imm  out  DATA_W  immediate byte; 0 for 1-byte instructions.
- instr_long  out  1  1 = instr_imm is meaningful.
- instr_pc  out  ADDR_W  address of the opcode byte.

Behaviour:
- Reset (reset==0 at an edge):
  - pc=RESET_PC, state=FETCH_OP.
  - instr_valid=0; instr_opcode, instr_imm, instr_pc = 0; instr_long=0.
  - Overrides redirect and every other input.
- FSM states: FETCH_OP, FETCH_IMM, HOLD. mem_addr=pc at all times.
- FETCH_OP, mem_rd=fetch_en:
  - If fetch_en=1: latch opcode=mem_rdata, instr_pc=pc, pc=pc+1.
    - If mem_rdata[LONG_BIT]=1: go to FETCH_IMM.
    - Otherwise: instr_imm=0, instr_long=0, go to HOLD.
  - If fetch_en=0: stay in FETCH_OP, nothing changes.
- FETCH_IMM, mem_rd=1: latch instr_imm=mem_rdata, instr_long=1, pc=pc+1, go to HOLD.
- HOLD, mem_rd=0, instr_valid=1:
  - Outputs are stable until the handshake completes (instr_valid & instr_ready at an edge).
  - Handshake: go to FETCH_OP.
  - No handshake: stay in HOLD.
- instr_valid is registered and is 1 exactly while state==HOLD.
- Latency from entering FETCH_OP with fetch_en=1 to instr_valid=1: 1 cycle for a 1-byte instruction, 2 cycles for a 2-byte instruction.
- Peak throughput: 1 instruction per 2 cycles (1-byte) or per 3 cycles (2-byte).
- PC arithmetic is modulo 2^ADDR_W:
  - 8'hFF+1 = 8'h00.
  - A 2-byte instruction at 8'hFF fetches its immediate from 8'h00.
- Redirect (higher priority than anything except reset), in any state:
  - Next edge: pc=redirect_pc, state=FETCH_OP, instr_valid=0.
  - A partially fetched instruction is discarded.
  - In HOLD with instr_ready=1 on the same edge, the handshake counts as completed (decode consumed it) and the redirect still applies.
  - In HOLD with instr_ready=0, the held instruction is dropped.
- fetch_en=0 does not affect FETCH_IMM or HOLD; an instruction already started completes.
- No memory writes are issued; the memory's write port is owned by the store path.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W and DATA_W constants.
  - LONG_BIT.
  - fetch state encoding FETCH_OP=2'd0, FETCH_IMM=2'd1, HOLD=2'd2.
- Single flat module; no sub-module. The PC incrementer is a single expression.

Test Plan:
- Reset release, RESET_PC=0, memory[0]=8'h12, instr_ready=1:
  - mem_addr=0, mem_rd=1 in the first cycle.
  - Next cycle instr_valid=1, opcode=8'h12, imm=0, long=0, instr_pc=0.
  - Then fetches from address 1.
- memory[4]=8'h85, memory[5]=8'h3C, start at pc=4:
  - Two cycles later instr_valid=1, opcode=8'h85, imm=8'h3C, long=1, instr_pc=4.
  - Next fetch address 6.
- Backpressure: instr_ready=0 for 5 cycles while in HOLD:
  - Outputs are stable and mem_rd=0 throughout.
  - After ready=1, exactly one handshake occurs and the next fetch starts the following cycle.
- Wrap: memory[8'hFF]=8'h90, memory[0]=8'h77, pc=8'hFF:
  - opcode=8'h90, imm=8'h77, instr_pc=8'hFF.
  - Next fetch address 8'h01.
- Redirect in FETCH_IMM with redirect_pc=8'h40:
  - Next cycle instr_valid=0 and mem_addr=8'h40.
  - The partial instruction is never presented.
  - Also check redirect together with instr_ready=1 in HOLD: one handshake, then fetch at 8'h40.
- reset=0 asserted mid-HOLD:
  - Next edge instr_valid=0 and all instruction outputs are 0.
  - pc=RESET_PC; resumes fetching after reset=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode length marker and the
// fetch FSM state encoding.
package cpu_pkg;

  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned DATA_W   = 8;
  // Opcode bit that marks a 2-byte (opcode + immediate) instruction.
  localparam int unsigned LONG_BIT = 7;

  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_IMM = 2'd1,
    HOLD      = 2'd2
  } fetch_state_e;

endpackage : cpu_pkg

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the PC, reads 1- or 2-byte instructions
// from a combinational-read memory and holds each assembled instruction
// for decode until a valid/ready handshake. Execute may redirect the PC.
//
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   fetch_en          allow new opcode fetches
//   mem_addr/mem_rd   memory read address (always pc) and read strobe
//   mem_rdata         memory read data, same cycle as mem_addr
//   redirect(_pc)     branch taken and its target
//   instr_valid/ready decode handshake
//   instr_opcode/imm/long/pc  held instruction payload
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_opcode,
  output logic [DATA_W-1:0] instr_imm,
  output logic              instr_long,
  output logic [ADDR_W-1:0] instr_pc
);

  fetch_state_e      state, state_d;
  logic [ADDR_W-1:0] pc, pc_d;
  logic [DATA_W-1:0] opcode_d, imm_d;
  logic              long_d;
  logic [ADDR_W-1:0] ipc_d;

  // The memory is always addressed by the PC.
  assign mem_addr = pc;

  // State and payload registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= FETCH_OP;
      pc           <= RESET_PC;
      instr_valid  <= 1'b0;
      instr_opcode <= '0;
      instr_imm    <= '0;
      instr_long   <= 1'b0;
      instr_pc     <= '0;
    end else begin
      state        <= state_d;
      pc           <= pc_d;
      // Valid is registered and tracks HOLD exactly.
      instr_valid  <= (state_d == HOLD);
      instr_opcode <= opcode_d;
      instr_imm    <= imm_d;
      instr_long   <= long_d;
      instr_pc     <= ipc_d;
    end
  end

  // Next-state, next-payload and read strobe.
  always_comb begin
    state_d  = state;
    pc_d     = pc;
    opcode_d = instr_opcode;
    imm_d    = instr_imm;
    long_d   = instr_long;
    ipc_d    = instr_pc;
    mem_rd   = 1'b0;

    unique case (state)
      FETCH_OP:  mem_rd = fetch_en;
      FETCH_IMM: mem_rd = 1'b1;
      default:   mem_rd = 1'b0;
    endcase

    if (redirect) begin
      // Discards any partial or held instruction; a same-edge handshake
      // in HOLD has already been consumed by decode.
      pc_d    = redirect_pc;
      state_d = FETCH_OP;
    end else begin
      unique case (state)
        FETCH_OP: begin
          if (fetch_en) begin
            opcode_d = mem_rdata;
            ipc_d    = pc;
            pc_d     = ADDR_W'(pc + 1'b1);
            if (mem_rdata[LONG_BIT]) begin
              state_d = FETCH_IMM;
            end else begin
              imm_d   = '0;
              long_d  = 1'b0;
              state_d = HOLD;
            end
          end
        end
        FETCH_IMM: begin
          imm_d   = mem_rdata;
          long_d  = 1'b1;
          pc_d    = ADDR_W'(pc + 1'b1);
          state_d = HOLD;
        end
        HOLD: begin
          if (instr_ready) state_d = FETCH_OP;
        end
        default: state_d = FETCH_OP;
      endcase
    end
  end

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected instructions,
// a negedge monitor pops and compares on every decode handshake.
module tb_fetch_unit;
  import cpu_pkg::*;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] imm;
    logic       lng;
    logic [7:0] pc;
  } instr_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              fetch_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_opcode;
  logic [DATA_W-1:0] instr_imm;
  logic              instr_long;
  logic [ADDR_W-1:0] instr_pc;

  logic [7:0] mem [256];
  instr_t     exp_q [$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  fetch_unit #(.RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_imm(instr_imm),
    .instr_long(instr_long), .instr_pc(instr_pc)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake must match the oldest expected instruction.
  always @(negedge clk) begin
    if (reset && instr_valid && instr_ready) begin
      instr_t got;
      got = '{instr_opcode, instr_imm, instr_long, instr_pc};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_instr got=%0h exp=none", got);
      end else begin
        instr_t e;
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL instr got=%0h exp=%0h", got, e);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h12; mem[8'h01] = 8'h05;
    mem[8'h04] = 8'h85; mem[8'h05] = 8'h3C; mem[8'h06] = 8'h01;
    mem[8'hFF] = 8'h90; mem[8'h20] = 8'h81; mem[8'h40] = 8'h02;
    reset = 1'b0; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_opcode", 32'(instr_opcode), 32'h0);
    chk("rst_imm", 32'(instr_imm), 32'h0);
    chk("rst_long", 32'(instr_long), 32'h0);
    chk("rst_ipc", 32'(instr_pc), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);

    // Short instruction after reset release
    reset = 1'b1; fetch_en = 1'b1;
    exp_q.push_back('{8'h12, 8'h00, 1'b0, 8'h00});
    #1;
    chk("t1_addr", 32'(mem_addr), 32'h0);
    chk("t1_rd", 32'(mem_rd), 32'h1);
    tick();
    chk("t1_valid", 32'(instr_valid), 32'h1);
    chk("t1_hold_rd", 32'(mem_rd), 32'h0);
    chk("t1_next_addr", 32'(mem_addr), 32'h1);
    fetch_en = 1'b0;
    tick();
    chk("t1_done_valid", 32'(instr_valid), 32'h0);

    // Long instruction at 4 with backpressure
    redirect = 1'b1; redirect_pc = 8'h04;
    tick();
    redirect = 1'b0;
    chk("t2_addr", 32'(mem_addr), 32'h4);
    exp_q.push_back('{8'h85, 8'h3C, 1'b1, 8'h04});
    fetch_en = 1'b1;
    tick();
    chk("t2_imm_valid", 32'(instr_valid), 32'h0);
    chk("t2_imm_addr", 32'(mem_addr), 32'h5);
    chk("t2_imm_rd", 32'(mem_rd), 32'h1);
    fetch_en = 1'b0; instr_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(instr_valid), 32'h1);
      chk("bp_rd", 32'(mem_rd), 32'h0);
      chk("bp_payload", 32'({instr_opcode, instr_imm, instr_long, instr_pc}),
          32'({8'h85, 8'h3C, 1'b1, 8'h04}));
      chk("bp_addr", 32'(mem_addr), 32'h6);
      tick();
    end
    exp_q.push_back('{8'h01, 8'h00, 1'b0, 8'h06});
    instr_ready = 1'b1; fetch_en = 1'b1;
    tick();
    chk("bp_rel_valid", 32'(instr_valid), 32'h0);
    chk("bp_rel_addr", 32'(mem_addr), 32'h6);
    chk("bp_rel_rd", 32'(mem_rd), 32'h1);
    tick();
    chk("t3_valid", 32'(instr_valid), 32'h1);
    fetch_en = 1'b0;
    tick();
    chk("t3_addr", 32'(mem_addr), 32'h7);

    // Wrap: long instruction at FF takes its immediate from 00
    mem[8'h00] = 8'h77;
    redirect = 1'b1; redirect_pc = 8'hFF;
    tick();
    redirect = 1'b0;
    exp_q.push_back('{8'h90, 8'h77, 1'b1, 8'hFF});
    fetch_en = 1'b1;
    tick();
    chk("wrap_imm_addr", 32'(mem_addr), 32'h0);
    fetch_en = 1'b0;
    tick();
    chk("wrap_valid", 32'(instr_valid), 32'h1);
    tick();
    chk("wrap_next_addr", 32'(mem_addr), 32'h1);

    // Redirect during FETCH_IMM drops the partial instruction
    redirect = 1'b1; redirect_pc = 8'h20;
    tick();
    redirect = 1'b0; fetch_en = 1'b1;
    tick();
    redirect = 1'b1; redirect_pc = 8'h40; fetch_en = 1'b0;
    tick();
    redirect = 1'b0;
    chk("rd_imm_valid", 32'(instr_valid), 32'h0);
    chk("rd_imm_addr", 32'(mem_addr), 32'h40);
    tick(); tick();
    chk("rd_imm_idle", 32'(instr_valid), 32'h0);

    // Redirect together with a handshake in HOLD
    exp_q.push_back('{8'h02, 8'h00, 1'b0, 8'h40});
    fetch_en = 1'b1;
    tick();
    chk("rd_hold_valid", 32'(instr_valid), 32'h1);
    redirect = 1'b1; redirect_pc = 8'h40; fetch_en = 1'b0;
    tick();
    redirect = 1'b0;
    chk("rd_hold_after_valid", 32'(instr_valid), 32'h0);
    chk("rd_hold_addr", 32'(mem_addr), 32'h40);

    // Reset asserted mid-HOLD
    instr_ready = 1'b0; fetch_en = 1'b1;
    tick();
    chk("mrst_hold_valid", 32'(instr_valid), 32'h1);
    fetch_en = 1'b0; reset = 1'b0;
    tick();
    chk("mrst_valid", 32'(instr_valid), 32'h0);
    chk("mrst_payload", 32'({instr_opcode, instr_imm, instr_long, instr_pc}), 32'h0);
    chk("mrst_addr", 32'(mem_addr), 32'h0);
    reset = 1'b1; instr_ready = 1'b1; fetch_en = 1'b1;
    exp_q.push_back('{8'h77, 8'h00, 1'b0, 8'h00});
    tick();
    chk("mrst_resume_valid", 32'(instr_valid), 32'h1);
    fetch_en = 1'b0;
    tick(); tick();

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fetch_unit
